// File: rtl/ad9866_emu_if.sv
// rtl/ad9866_emu_if.sv - AD9866 6-bit nibble bus plus command snoop bus between FPGA side and emulator
interface ad9866_emu_if;
   logic [5:0]  rffe_ad9866_tx;
   logic        rffe_ad9866_txsync;
   logic        rffe_ad9866_txquiet_n;
   logic        rffe_ad9866_pga5;
   logic [5:0]  rffe_ad9866_rx;
   logic        rffe_ad9866_rxsync;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_rqst;

   modport master (
      output rffe_ad9866_tx, rffe_ad9866_txsync, rffe_ad9866_txquiet_n, rffe_ad9866_pga5,
      output cmd_addr, cmd_data, cmd_rqst,
      input  rffe_ad9866_rx, rffe_ad9866_rxsync
   );

   modport slave (
      input  rffe_ad9866_tx, rffe_ad9866_txsync, rffe_ad9866_txquiet_n, rffe_ad9866_pga5,
      input  cmd_addr, cmd_data, cmd_rqst,
      output rffe_ad9866_rx, rffe_ad9866_rxsync
   );
endinterface

// File: rtl/ad9866_emu.sv
// rtl/ad9866_emu.sv - AD9866 far-end emulator: TX deframe, RX framing, config snoop (AD9866EMU_NOISE_EN adds LFSR dither)
module ad9866_emu #(
   parameter logic [5:0] CMD_ADDR = 6'h3a,
   parameter int         LB_SHIFT = 0
) (
   input  logic        clk,
   input  logic        rst,
   ad9866_emu_if.slave bus,
   output logic [5:0]  gain,
   output logic [11:0] tx_word,
   output logic        tx_word_valid,
   output logic        tx_frame_err
);
   localparam logic [1:0] SRC_ZERO = 2'd0;
   localparam logic [1:0] SRC_LOOP = 2'd1;
   localparam logic [1:0] SRC_RAMP = 2'd2;

   logic [5:0]  hold_hi_q, hold_hi_d, gain_q, gain_d, rx_q, rx_d;
   logic        gain_cyc_q, gain_cyc_d, prev_sync_q, prev_sync_d;
   logic [11:0] tx_word_q, tx_word_d, rx_hold_q, rx_hold_d;
   logic        tx_valid_q, tx_valid_d, err_q, err_d, phase_q, phase_d, rxsync_q, rxsync_d;
   logic [1:0]  src_q, src_d, pend_src_q, pend_src_d;
   logic [11:0] step_q, step_d, pend_step_q, pend_step_d, acc_q, acc_d;
   logic        pend_q, pend_d, clip_q, clip_d;

   logic        cmd_hit, src_chg, clip_base;
   logic [1:0]  eff_src;
   logic [11:0] eff_step, acc_base, src_word, lb_word, noise;
   logic        unused_cmd_bits;

   assign unused_cmd_bits = ^{bus.cmd_data[31:16], bus.cmd_data[3:2]};

`ifdef AD9866EMU_NOISE_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (!phase_q)
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end

   assign noise = {10'd0, lfsr_q[1:0]};
`else
   assign noise = 12'd0;
`endif

   always_comb begin
      hold_hi_d   = hold_hi_q;
      gain_d      = gain_q;
      gain_cyc_d  = gain_cyc_q;
      prev_sync_d = prev_sync_q;
      tx_word_d   = tx_word_q;
      tx_valid_d  = 1'b0;
      err_d       = err_q;

      if (!bus.rffe_ad9866_txsync) begin
         hold_hi_d   = bus.rffe_ad9866_tx;
         prev_sync_d = 1'b0;
         gain_cyc_d  = bus.rffe_ad9866_pga5;
         if (bus.rffe_ad9866_pga5) gain_d = bus.rffe_ad9866_tx;
      end else begin
         prev_sync_d = 1'b1;
         gain_cyc_d  = 1'b0;
         if (bus.rffe_ad9866_txquiet_n) begin
            // Misframed words are still delivered so loopback keeps flowing; only the flag records it.
            tx_word_d  = {hold_hi_q, bus.rffe_ad9866_tx};
            tx_valid_d = 1'b1;
            if (prev_sync_q || gain_cyc_q) err_d = 1'b1;
         end
      end
   end

   always_comb begin
      cmd_hit   = bus.cmd_rqst && (bus.cmd_addr == CMD_ADDR);
      eff_src   = pend_q ? pend_src_q : src_q;
      eff_step  = pend_q ? pend_step_q : step_q;
      src_chg   = pend_q && (pend_src_q != src_q);
      acc_base  = src_chg ? 12'd0 : acc_q;
      clip_base = src_chg ? 1'b0 : clip_q;
      lb_word   = bus.rffe_ad9866_txquiet_n ? 12'($signed(tx_word_q) >>> LB_SHIFT) : 12'd0;

      src_word = 12'd0;
      acc_d    = acc_q;
      clip_d   = clip_q;
      src_d    = src_q;
      step_d   = step_q;
      pend_d   = pend_q | cmd_hit;
      pend_src_d  = cmd_hit ? bus.cmd_data[1:0] : pend_src_q;
      pend_step_d = cmd_hit ? bus.cmd_data[15:4] : pend_step_q;
      rx_hold_d = rx_hold_q;
      phase_d   = ~phase_q;

      if (!phase_q) begin
         // Word boundary: the only place config lands, so a word never mixes two sources.
         src_d  = eff_src;
         step_d = eff_step;
         acc_d  = acc_base;
         clip_d = clip_base;
         case (eff_src)
            SRC_ZERO: src_word = 12'd0;
            SRC_LOOP: src_word = lb_word;
            SRC_RAMP: begin
               src_word = acc_base;
               acc_d    = acc_base + eff_step;
            end
            default: begin
               src_word = clip_base ? 12'h800 : 12'h7FF;
               clip_d   = ~clip_base;
            end
         endcase
         pend_d    = cmd_hit;
         rx_hold_d = src_word ^ noise;
         rx_d      = rx_hold_d[11:6];
         rxsync_d  = 1'b0;
      end else begin
         rx_d     = rx_hold_q[5:0];
         rxsync_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_hi_q   <= '0;
         gain_q      <= '0;
         gain_cyc_q  <= 1'b0;
         prev_sync_q <= 1'b0;
         tx_word_q   <= '0;
         tx_valid_q  <= 1'b0;
         err_q       <= 1'b0;
         phase_q     <= 1'b0;
         rx_hold_q   <= '0;
         rx_q        <= '0;
         rxsync_q    <= 1'b0;
         src_q       <= SRC_ZERO;
         step_q      <= '0;
         pend_q      <= 1'b0;
         pend_src_q  <= SRC_ZERO;
         pend_step_q <= '0;
         acc_q       <= '0;
         clip_q      <= 1'b0;
      end else begin
         hold_hi_q   <= hold_hi_d;
         gain_q      <= gain_d;
         gain_cyc_q  <= gain_cyc_d;
         prev_sync_q <= prev_sync_d;
         tx_word_q   <= tx_word_d;
         tx_valid_q  <= tx_valid_d;
         err_q       <= err_d;
         phase_q     <= phase_d;
         rx_hold_q   <= rx_hold_d;
         rx_q        <= rx_d;
         rxsync_q    <= rxsync_d;
         src_q       <= src_d;
         step_q      <= step_d;
         pend_q      <= pend_d;
         pend_src_q  <= pend_src_d;
         pend_step_q <= pend_step_d;
         acc_q       <= acc_d;
         clip_q      <= clip_d;
      end
   end

   assign bus.rffe_ad9866_rx     = rx_q;
   assign bus.rffe_ad9866_rxsync = rxsync_q;
   assign gain          = gain_q;
   assign tx_word       = tx_word_q;
   assign tx_word_valid = tx_valid_q;
   assign tx_frame_err  = err_q;
endmodule

// File: tb/tb_ad9866_emu.sv
// tb/tb_ad9866_emu.sv - scoreboard bench for ad9866_emu with a word-level reference model
module tb_ad9866_emu;
   localparam logic [5:0] CADDR = 6'h3a;
   localparam int         LB    = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ad9866_emu_if bus ();
   logic [5:0]  gain;
   logic [11:0] tx_word;
   logic        tx_word_valid, tx_frame_err;

   ad9866_emu #(.CMD_ADDR(CADDR), .LB_SHIFT(LB)) dut (
      .clk(clk), .rst(rst), .bus(bus), .gain(gain), .tx_word(tx_word),
      .tx_word_valid(tx_word_valid), .tx_frame_err(tx_frame_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [11:0] rx_exp[$];
   logic [11:0] tx_exp[$];

   // Reference model state
   logic [1:0]  m_src, m_pend_src;
   logic [11:0] m_step, m_pend_step, m_acc, m_latest;
   logic        m_clip, m_pend, m_psync, m_gcyc, m_err, chk_rel;
   logic [5:0]  m_hold, m_gain;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [5:0] mon_hi;
   always @(negedge clk) begin
      if (bus.rffe_ad9866_rxsync === 1'b1) begin
         if (rx_exp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_word: got %0h expected none", {mon_hi, bus.rffe_ad9866_rx});
         end else
            check("rx_word", {mon_hi, bus.rffe_ad9866_rx}, rx_exp.pop_front());
      end else
         mon_hi = bus.rffe_ad9866_rx;
      if (tx_word_valid === 1'b1) begin
         if (tx_exp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_word: got %0h expected none", tx_word);
         end else
            check("tx_word", tx_word, tx_exp.pop_front());
      end
   end

   function automatic logic [11:0] lb_of(input logic [11:0] w);
      logic signed [11:0] s;
      s = w;
      return 12'(s >>> LB);
   endfunction

   task automatic model_reset();
      m_src = 0; m_step = 0; m_acc = 0; m_clip = 0; m_latest = 0; m_pend = 0;
      m_pend_src = 0; m_pend_step = 0; m_hold = 0; m_psync = 0; m_gcyc = 0;
      m_gain = 0; m_err = 0;
   endtask

   task automatic tx_model(input logic [5:0] nib, input logic sync, input logic pga5, input logic quiet);
      if (!sync) begin
         m_hold = nib;
         m_gcyc = pga5;
         if (pga5) m_gain = nib;
         m_psync = 0;
      end else begin
         if (quiet) begin
            if (m_psync || m_gcyc) m_err = 1;
            m_latest = {m_hold, nib};
            tx_exp.push_back(m_latest);
         end
         m_psync = 1;
         m_gcyc = 0;
      end
   endtask

   task automatic drive(input logic [5:0] nib, input logic sync, input logic pga5, input logic quiet,
                        input logic rqst, input logic [5:0] addr, input logic [31:0] data);
      bus.rffe_ad9866_tx        = nib;
      bus.rffe_ad9866_txsync    = sync;
      bus.rffe_ad9866_pga5      = pga5;
      bus.rffe_ad9866_txquiet_n = quiet;
      bus.cmd_rqst = rqst;
      bus.cmd_addr = addr;
      bus.cmd_data = data;
      tx_model(nib, sync, pga5, quiet);
      if (rqst && addr == CADDR) begin
         m_pend = 1; m_pend_src = data[1:0]; m_pend_step = data[15:4];
      end
      @(negedge clk);
   endtask

   // One RX word period. mode: 0 normal, 1 gain nibble, 2 txsync on hi cycle, 3 pga5 then txsync.
   task automatic word(input logic [5:0] hi, input logic [5:0] lo, input logic quiet, input int mode,
                       input logic rqst, input logic [5:0] addr, input logic [31:0] data);
      logic [11:0] w;
      if (m_pend) begin
         if (m_pend_src != m_src) begin m_acc = 0; m_clip = 0; end
         m_src = m_pend_src; m_step = m_pend_step; m_pend = 0;
      end
      case (m_src)
         2'd0: w = 12'h000;
         2'd1: w = quiet ? lb_of(m_latest) : 12'h000;
         2'd2: begin w = m_acc; m_acc = m_acc + m_step; end
         default: begin w = m_clip ? 12'h800 : 12'h7FF; m_clip = ~m_clip; end
      endcase
      rx_exp.push_back(w);
      drive(hi, mode == 2, mode == 1 || mode == 3, quiet, 1'b0, 6'd0, 32'd0);
      if (chk_rel) check("rel_first_hi", {bus.rffe_ad9866_rxsync, bus.rffe_ad9866_rx}, 7'h00);
      drive(lo, mode != 1, 1'b0, quiet, rqst, addr, data);
      if (chk_rel) check("rel_rxsync", bus.rffe_ad9866_rxsync, 1'b1);
      chk_rel = 0;
      check("gain", gain, m_gain);
      check("frame_err", tx_frame_err, m_err);
   endtask

   task automatic rnd_word(input int mode);
      logic [5:0] bad_addr;
      logic       rq;
      bad_addr = CADDR ^ 6'(1 + $urandom % 63);
      rq = ($urandom % 5 == 0);
      word(6'($urandom), 6'($urandom), 1'b1, mode, rq, bad_addr, $urandom);
   endtask

   task automatic cfg(input logic [1:0] src, input logic [11:0] step);
      word(6'($urandom), 6'($urandom), 1'b1, 0, 1'b1, CADDR, {16'($urandom), step, 2'($urandom), src});
   endtask

   task automatic do_reset(input int n);
      rst = 1;
      bus.rffe_ad9866_txsync = 0; bus.rffe_ad9866_pga5 = 0; bus.cmd_rqst = 0;
      repeat (n) @(negedge clk);
      rx_exp.delete();
      tx_exp.delete();
      model_reset();
      check("rst_rx", {bus.rffe_ad9866_rxsync, bus.rffe_ad9866_rx}, 7'h00);
      check("rst_gain", gain, 6'h00);
      check("rst_tx_word", tx_word, 12'h000);
      check("rst_valid", tx_word_valid, 1'b0);
      check("rst_frame_err", tx_frame_err, 1'b0);
      chk_rel = 1;
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      bus.rffe_ad9866_tx = 0; bus.rffe_ad9866_txsync = 0; bus.rffe_ad9866_txquiet_n = 1;
      bus.rffe_ad9866_pga5 = 0; bus.cmd_addr = 0; bus.cmd_data = 0; bus.cmd_rqst = 0;
      chk_rel = 0;
      model_reset();
      rst = 1;
      @(negedge clk);
      do_reset(4);
      repeat (4) rnd_word(0);

      cfg(2'd1, 12'h000);
      word(6'h29, 6'h1C, 1'b1, 0, 1'b0, 6'd0, 32'd0);
      for (int i = 0; i < 30; i++) begin
         if ($urandom % 4 == 0)
            word(6'($urandom), 6'($urandom), 1'($urandom % 4 != 0), 0, 1'b0, 6'd0, 32'd0);
         else
            rnd_word(($urandom % 6 == 0) ? 1 : 0);
      end
      word(6'h2A, 6'($urandom), 1'b1, 1, 1'b0, 6'd0, 32'd0);

      cfg(2'd2, 12'h400);
      repeat (6) rnd_word(0);
      cfg(2'd2, 12'($urandom));
      repeat (8) rnd_word(0);
      cfg(2'd3, 12'($urandom));
      repeat (8) rnd_word(0);
      cfg(2'd2, 12'h123);
      repeat (6) rnd_word(0);
      cfg(2'd1, 12'h000);
      repeat (10) rnd_word(0);

      drive(6'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'd0);
      do_reset(3);
      repeat (3) rnd_word(0);

      cfg(2'd1, 12'h000);
      repeat (2) rnd_word(0);
      rnd_word(2);
      repeat (3) rnd_word(0);
      do_reset(2);
      word(6'($urandom), 6'($urandom), 1'b0, 2, 1'b0, 6'd0, 32'd0);
      rnd_word(0);
      rnd_word(3);
      repeat (2) rnd_word(0);

      bus.rffe_ad9866_txsync = 0; bus.rffe_ad9866_pga5 = 0; bus.cmd_rqst = 0;
      @(negedge clk);
      check("rx_drain", rx_exp.size(), 0);
      check("tx_drain", tx_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
